packet_display_feeder: RTL and testbench

- Upstream neighbour of the 7-segment display driver.
- Accepts 38-bit packets from the datapath over a valid/ready handshake and buffers them in a small synchronous FIFO.
- Presents one packet at a time on a registered output bus, holding each for at least HOLD_CYCLES clocks so a human can read it.
- The display stage consumes PACKET_OUT directly; PACKET_OUT[7:0] are the two displayed nibbles.

---
 rtl/packet_display_feeder_pkg.sv | 14 +
 rtl/packet_display_feeder_if.sv | 34 +++
 rtl/packet_display_feeder_pkt_fifo.sv | 62 ++++++
 rtl/packet_display_feeder.sv | 115 +++++++++++
 tb/tb_packet_display_feeder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_display_feeder_pkg.sv
// Shared types and constants for the packet display feeder.
// Holds the default packet width, FSM encoding and reset values.
package packet_display_feeder_pkg;

    localparam int PW_DEF = 38;
    localparam int DROP_W = 8;
    localparam logic [PW_DEF-1:0] OUT_RST = '0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/packet_display_feeder_if.sv
// Upstream handshake plus display-side outputs of the feeder.
// master: datapath/observer side; slave: the feeder itself.
interface packet_display_feeder_if
    import packet_display_feeder_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = 4
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic [PW-1:0]     in_packet;
    logic              in_ready;
    logic [PW-1:0]     packet_out;
    logic              out_update;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output flush, in_valid, in_packet,
        input  in_ready, packet_out, out_update,
        input  count, overflow, drop_cnt
    );

    modport slave (
        input  flush, in_valid, in_packet,
        output in_ready, packet_out, out_update,
        output count, overflow, drop_cnt
    );

endinterface

// File: rtl/packet_display_feeder_pkt_fifo.sv
// Synchronous FIFO with push, pop, drop_head and flush.
// Ports: clk, rst, flush, push/din, pop, drop_head -> head, count, full, empty.
module pkt_fifo
    import packet_display_feeder_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [PW-1:0] din,
    input  logic          pop,
    input  logic          drop_head,
    output logic [PW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          adv;

    // A pop and a drop both retire the head entry.
    assign adv   = pop | drop_head;
    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !adv) begin
                count <= count + 1'b1;
            end else if (adv && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_display_feeder.sv
// Buffers packets and shows each on packet_out for >= HOLD_CYCLES clocks.
// Ports: clk, rst (sync, active-high), bus (slave: handshake, display, stats).
module packet_display_feeder
    import packet_display_feeder_pkg::*;
#(
    parameter int PW          = PW_DEF,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int DROP_OLDEST = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    packet_display_feeder_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [PW-1:0]     packet_out;
    logic              out_update;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    logic [PW-1:0]     head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic              drop_head;
    logic              expire;

    // Ready depends on registered occupancy only: no pop bypass.
    assign in_ready = !rst && !bus.flush &&
                      ((DROP_OLDEST != 0) || !full);
    assign push     = bus.in_valid && in_ready;
    assign expire   = (state == HOLD) && (hold_cnt == '0);
    assign pop      = !rst && !bus.flush && !empty &&
                      ((state == IDLE) || expire);
    // A concurrent pop frees a slot, so only push-without-pop drops.
    assign drop_head = (DROP_OLDEST != 0) && push && full && !pop;

    pkt_fifo #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (push),
        .din       (bus.in_packet),
        .pop       (pop),
        .drop_head (drop_head),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            packet_out <= PW'(OUT_RST);
            out_update <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else if (bus.flush) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            out_update <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            out_update <= pop;
            if (pop) begin
                packet_out <= head;
                hold_cnt   <= HOLD_INIT;
                state      <= HOLD;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (drop_head) begin
                overflow <= 1'b1;
                if (drop_cnt != {DROP_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.packet_out = packet_out;
    assign bus.out_update = out_update;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_packet_display_feeder.sv
// Directed bench: dut0 back-pressures (DROP_OLDEST=0), dut1 drops oldest.
// Both use DEPTH=4, HOLD_CYCLES=10 and share clk/rst.
module tb_packet_display_feeder;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   cyc;
    logic saw_block0;

    logic [37:0] q0 [$];
    int          t0 [$];
    logic [37:0] q1 [$];

    packet_display_feeder_if #(.PW(38), .DEPTH(4)) b0 ();
    packet_display_feeder_if #(.PW(38), .DEPTH(4)) b1 ();

    packet_display_feeder #(
        .PW(38), .DEPTH(4), .HOLD_CYCLES(10), .DROP_OLDEST(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    packet_display_feeder #(
        .PW(38), .DEPTH(4), .HOLD_CYCLES(10), .DROP_OLDEST(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b0.out_update === 1'b1) begin
            q0.push_back(b0.packet_out);
            t0.push_back(cyc);
        end
        if (b1.out_update === 1'b1) begin
            q1.push_back(b1.packet_out);
        end
        if (b0.count == 3'd4 && b0.in_ready == 1'b0 &&
            b0.flush == 1'b0 && rst == 1'b0) begin
            saw_block0 = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        total++;
        if (b0.packet_out !== 38'h0)
            $display("FAIL rst_pkt0 got %h want 0", b0.packet_out);
        else passed++;
        total++;
        if (b0.count !== 3'd0)
            $display("FAIL rst_count0 got %0d want 0", b0.count);
        else passed++;
        total++;
        if (b0.in_ready !== 1'b1)
            $display("FAIL rst_ready0 got %b want 1", b0.in_ready);
        else passed++;
        total++;
        if (b1.in_ready !== 1'b1)
            $display("FAIL rst_ready1 got %b want 1", b1.in_ready);
        else passed++;
        total++;
        if (b0.overflow !== 1'b0 || b0.drop_cnt !== 8'd0)
            $display("FAIL rst_stats0 got %b/%0d want 0/0",
                     b0.overflow, b0.drop_cnt);
        else passed++;
        total++;
        if (b1.packet_out !== 38'h0 || b1.out_update !== 1'b0)
            $display("FAIL rst_out1 got %h/%b want 0/0",
                     b1.packet_out, b1.out_update);
        else passed++;
        q0.delete();
        q1.delete();
        repeat (6) tick();
        total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL idle_no_update got %0d/%0d want 0/0",
                     q0.size(), q1.size());
        else passed++;
    endtask

    task automatic test_single;
        q0.delete();
        b0.in_valid  = 1'b1;
        b0.in_packet = 38'hA5;
        tick();
        b0.in_valid = 1'b0;
        total++;
        if (b0.count !== 3'd1 || b0.packet_out !== 38'h0)
            $display("FAIL single_push got cnt %0d pkt %h want 1/0",
                     b0.count, b0.packet_out);
        else passed++;
        tick();
        total++;
        if (b0.packet_out !== 38'hA5 || b0.out_update !== 1'b1)
            $display("FAIL single_show got %h/%b want a5/1",
                     b0.packet_out, b0.out_update);
        else passed++;
        total++;
        if (b0.count !== 3'd0)
            $display("FAIL single_pop got %0d want 0", b0.count);
        else passed++;
        repeat (33) tick();
        total++;
        if (b0.packet_out !== 38'hA5 || b0.out_update !== 1'b0)
            $display("FAIL single_persist got %h/%b want a5/0",
                     b0.packet_out, b0.out_update);
        else passed++;
        total++;
        if (q0.size() != 1)
            $display("FAIL single_pulses got %0d want 1", q0.size());
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [37:0] e [3];
        int n;
        e[0] = 38'h11;
        e[1] = 38'h22;
        e[2] = 38'h33;
        q0.delete();
        t0.delete();
        for (int i = 0; i < 3; i++) begin
            b0.in_valid  = 1'b1;
            b0.in_packet = e[i];
            tick();
        end
        b0.in_valid = 1'b0;
        n = 0;
        while (q0.size() < 3 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (q0.size() != 3) begin
            $display("FAIL b2b_count got %0d want 3", q0.size());
        end else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (q0[i] !== e[i])
                    $display("FAIL b2b_data%0d got %h want %h",
                             i, q0[i], e[i]);
                else passed++;
            end
            total++;
            if (t0[1] - t0[0] != 10 || t0[2] - t0[1] != 10)
                $display("FAIL b2b_spacing got %0d/%0d want 10/10",
                         t0[1] - t0[0], t0[2] - t0[1]);
            else passed++;
        end
        repeat (15) tick();
        total++;
        if (q0.size() != 3)
            $display("FAIL b2b_exact got %0d want 3", q0.size());
        else passed++;
    endtask

    task automatic test_backpressure;
        int n;
        q0.delete();
        saw_block0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b0.in_valid  = 1'b1;
            b0.in_packet = 38'h41 + 38'(i);
            n = 0;
            while (b0.in_ready !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            tick();
        end
        b0.in_valid = 1'b0;
        n = 0;
        while (q0.size() < 6 && n < 120) begin
            tick();
            n++;
        end
        total++;
        if (q0.size() != 6) begin
            $display("FAIL bp_count got %0d want 6", q0.size());
        end else begin
            passed++;
            for (int i = 0; i < 6; i++) begin
                total++;
                if (q0[i] !== 38'h41 + 38'(i))
                    $display("FAIL bp_data%0d got %h want %h",
                             i, q0[i], 38'h41 + 38'(i));
                else passed++;
            end
        end
        total++;
        if (saw_block0 !== 1'b1)
            $display("FAIL bp_ready_low got %b want 1", saw_block0);
        else passed++;
        total++;
        if (b0.overflow !== 1'b0 || b0.drop_cnt !== 8'd0)
            $display("FAIL bp_no_ovf got %b/%0d want 0/0",
                     b0.overflow, b0.drop_cnt);
        else passed++;
    endtask

    task automatic test_overflow;
        logic [37:0] e [5];
        logic ready_ok;
        int n;
        e[0] = 38'h01;
        e[1] = 38'h04;
        e[2] = 38'h05;
        e[3] = 38'h06;
        e[4] = 38'h07;
        q1.delete();
        ready_ok = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            b1.in_valid  = 1'b1;
            b1.in_packet = 38'(i);
            #1;
            if (b1.in_ready !== 1'b1) ready_ok = 1'b0;
            tick();
        end
        b1.in_valid = 1'b0;
        total++;
        if (ready_ok !== 1'b1)
            $display("FAIL ovf_ready got %b want 1", ready_ok);
        else passed++;
        total++;
        if (b1.overflow !== 1'b1)
            $display("FAIL ovf_flag got %b want 1", b1.overflow);
        else passed++;
        total++;
        if (b1.drop_cnt !== 8'd2)
            $display("FAIL ovf_drops got %0d want 2", b1.drop_cnt);
        else passed++;
        total++;
        if (b1.count !== 3'd4)
            $display("FAIL ovf_count got %0d want 4", b1.count);
        else passed++;
        n = 0;
        while (q1.size() < 5 && n < 80) begin
            tick();
            n++;
        end
        repeat (12) tick();
        total++;
        if (q1.size() != 5) begin
            $display("FAIL ovf_shown got %0d want 5", q1.size());
        end else begin
            passed++;
            for (int i = 0; i < 5; i++) begin
                total++;
                if (q1[i] !== e[i])
                    $display("FAIL ovf_data%0d got %h want %h",
                             i, q1[i], e[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_flush;
        repeat (12) tick();
        q0.delete();
        for (int i = 0; i < 4; i++) begin
            b0.in_valid  = 1'b1;
            b0.in_packet = 38'h22 + 38'(i);
            tick();
        end
        b0.in_valid = 1'b0;
        total++;
        if (b0.packet_out !== 38'h22 || b0.count !== 3'd3)
            $display("FAIL fl_setup got %h/%0d want 22/3",
                     b0.packet_out, b0.count);
        else passed++;
        b0.flush     = 1'b1;
        b0.in_valid  = 1'b1;
        b0.in_packet = 38'h99;
        b1.flush     = 1'b1;
        #1;
        total++;
        if (b0.in_ready !== 1'b0 || b1.in_ready !== 1'b0)
            $display("FAIL fl_ready got %b/%b want 0/0",
                     b0.in_ready, b1.in_ready);
        else passed++;
        tick();
        b0.flush    = 1'b0;
        b0.in_valid = 1'b0;
        b1.flush    = 1'b0;
        total++;
        if (b0.count !== 3'd0)
            $display("FAIL fl_count got %0d want 0", b0.count);
        else passed++;
        total++;
        if (b0.packet_out !== 38'h22 || b0.out_update !== 1'b0)
            $display("FAIL fl_keep got %h/%b want 22/0",
                     b0.packet_out, b0.out_update);
        else passed++;
        total++;
        if (b1.overflow !== 1'b0 || b1.drop_cnt !== 8'd0)
            $display("FAIL fl_stats got %b/%0d want 0/0",
                     b1.overflow, b1.drop_cnt);
        else passed++;
        repeat (5) tick();
        total++;
        if (b0.packet_out !== 38'h22 || q0.size() != 1)
            $display("FAIL fl_idle got %h/%0d want 22/1",
                     b0.packet_out, q0.size());
        else passed++;
        b0.in_valid  = 1'b1;
        b0.in_packet = 38'h77;
        tick();
        b0.in_valid = 1'b0;
        tick();
        total++;
        if (b0.packet_out !== 38'h77 || b0.out_update !== 1'b1)
            $display("FAIL fl_after got %h/%b want 77/1",
                     b0.packet_out, b0.out_update);
        else passed++;
    endtask

    task automatic test_reset_mid_hold;
        b0.in_valid  = 1'b1;
        b0.in_packet = 38'h88;
        tick();
        b0.in_packet = 38'h89;
        tick();
        b0.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (b0.count !== 3'd0 || b0.packet_out !== 38'h0 ||
            b0.out_update !== 1'b0)
            $display("FAIL mid_rst got %0d/%h/%b want 0/0/0",
                     b0.count, b0.packet_out, b0.out_update);
        else passed++;
        repeat (15) tick();
        total++;
        if (b0.packet_out !== 38'h0)
            $display("FAIL mid_rst_lost got %h want 0", b0.packet_out);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        total      = 0;
        passed     = 0;
        cyc        = 0;
        saw_block0 = 1'b0;
        rst        = 1'b1;
        b0.flush     = 1'b0;
        b0.in_valid  = 1'b0;
        b0.in_packet = '0;
        b1.flush     = 1'b0;
        b1.in_valid  = 1'b0;
        b1.in_packet = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_flush();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
